usr_reg_version_ctrl: RTL

Controller that qualifies the bitstream user-register word delivered by the USR_ACCESSE2 configuration primitive and shares it between two register-bus requesters. The raw word and its valid flag are asynchronous to the fabric clock, so the block synchronises the flag and waits until the word has been stable for a programmable number of cycles before locking it. It then serves field-decoded reads to the processor-interface and protocol-responder paths through a round-robin arbiter. It sits between the USR_ACCESS wrapper and the version/status register readers.

---
 rtl/usr_reg_version_ctrl_pkg.sv | 39 +++
 rtl/cdc_sync_bit.sv | 24 ++
 rtl/usr_reg_version_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/usr_reg_version_ctrl_pkg.sv
// Shared types and constants for the user-register version controller.
// Relock support is selected in the top file by the USR_REG_RELOCK_EN macro.
package usr_reg_version_ctrl_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        StWaitValid = 2'd0,
        StQualify   = 2'd1,
        StLocked    = 2'd2,
        StFault     = 2'd3
    } state_t;

    localparam logic [1:0] SEL_RAW    = 2'd0;
    localparam logic [1:0] SEL_VER    = 2'd1;
    localparam logic [1:0] SEL_DATE   = 2'd2;
    localparam logic [1:0] SEL_STATUS = 2'd3;

    localparam int unsigned STAT_RELOCK_BIT = 0;
    localparam int unsigned STAT_VALID_BIT  = 1;
    localparam int unsigned STAT_READY_BIT  = 2;
    localparam int unsigned STAT_FAULT_BIT  = 3;

    function automatic logic [WORD_W-1:0] fieldDecode(input logic [WORD_W-1:0] word,
                                                      input logic [1:0]        sel,
                                                      input logic [3:0]        status);
        logic [WORD_W-1:0] res;
        res = '0;
        unique case (sel)
            SEL_RAW:    res = word;
            SEL_VER:    res = {16'h0, word[15:0]};
            SEL_DATE:   res = {16'h0, word[31:16]};
            SEL_STATUS: res = {28'h0, status};
            default:    res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Two-flop synchroniser for a single asynchronous level into the fabric clock.
module cdc_sync_bit (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;
    logic stable;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta   <= 1'b0;
            stable <= 1'b0;
        end else begin
            meta   <= d;
            stable <= meta;
        end
    end

    assign q = stable;

endmodule

// File: rtl/usr_reg_version_ctrl.sv
// Qualifies the USR_ACCESS user word, locks it once stable and serves field reads to two
// requesters through a round-robin arbiter. Define USR_REG_RELOCK_EN to enable relock.
module usr_reg_version_ctrl
    import usr_reg_version_ctrl_pkg::*;
#(
    parameter int unsigned STABLE_COUNT   = 16,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] usr_data,
    input  logic              usr_valid,
    input  logic              relock,
    input  logic [1:0]        req,
    input  logic [3:0]        sel,
    output logic [1:0]        gnt,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_err,
    output logic              version_ready,
    output logic              fault
);

`ifdef USR_REG_RELOCK_EN
    localparam logic RELOCK_COMPILED = 1'b1;
`else
    localparam logic RELOCK_COMPILED = 1'b0;
`endif

    localparam logic [7:0]  STAB_LAST   = 8'(STABLE_COUNT - 1);
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

    logic              validS;
    logic              relockHit;
    logic [WORD_W-1:0] sampleQ, prevQ;
    state_t            stateQ, stateD;
    logic [7:0]        stabCntQ, stabCntD;
    logic [15:0]       toCntQ, toCntD;
    logic [WORD_W-1:0] lockedWordQ, lockedWordD;

    logic [1:0]        gntQ, pick, eligible;
    logic              ptrQ;
    logic              arbActive;
    logic [1:0]        selG;
    logic [3:0]        status;
    logic [WORD_W-1:0] rdDataQ, readWord;
    logic              rdValidQ, rdErrQ;

`ifdef USR_REG_RELOCK_EN
    assign relockHit = relock;
`else
    logic unusedRelock;
    assign unusedRelock = relock;
    assign relockHit    = 1'b0;
`endif

    cdc_sync_bit uValidSync (
        .clk (clk),
        .rst (rst),
        .d   (usr_valid),
        .q   (validS)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sampleQ     <= '0;
            prevQ       <= '0;
            stateQ      <= StWaitValid;
            stabCntQ    <= '0;
            toCntQ      <= '0;
            lockedWordQ <= '0;
        end else begin
            sampleQ     <= usr_data;
            prevQ       <= sampleQ;
            stateQ      <= stateD;
            stabCntQ    <= stabCntD;
            toCntQ      <= toCntD;
            lockedWordQ <= lockedWordD;
        end
    end

    always_comb begin
        stateD      = stateQ;
        stabCntD    = stabCntQ;
        lockedWordD = lockedWordQ;
        toCntD      = toCntQ;
        if (stateQ != StLocked && toCntQ != TIMEOUT_LIM) begin
            toCntD = toCntQ + 16'd1;
        end
        if (relockHit) begin
            toCntD = '0;
        end

        unique case (stateQ)
            StWaitValid: begin
                stabCntD = '0;
                if (toCntQ == TIMEOUT_LIM) begin
                    stateD = StFault;
                end else if (validS) begin
                    stateD = StQualify;
                end
            end
            StQualify: begin
                if (toCntQ == TIMEOUT_LIM) begin
                    stateD = StFault;
                end else if (!validS) begin
                    stabCntD = '0;
                    stateD   = StWaitValid;
                end else if (sampleQ == prevQ) begin
                    if (stabCntQ == STAB_LAST) begin
                        lockedWordD = sampleQ;
                        stateD      = StLocked;
                    end else begin
                        stabCntD = stabCntQ + 8'd1;
                    end
                end else begin
                    // Any change restarts the stability run, even on the terminal count.
                    stabCntD = '0;
                end
            end
            StLocked, StFault: begin
                if (relockHit) begin
                    lockedWordD = '0;
                    stabCntD    = '0;
                    stateD      = StWaitValid;
                end
            end
            default: stateD = StWaitValid;
        endcase
    end

    assign version_ready = (stateQ == StLocked);
    assign fault         = (stateQ == StFault);
    assign arbActive     = version_ready | fault;

    always_comb begin
        status                  = '0;
        status[STAT_RELOCK_BIT] = RELOCK_COMPILED;
        status[STAT_VALID_BIT]  = validS;
        status[STAT_READY_BIT]  = version_ready;
        status[STAT_FAULT_BIT]  = fault;

        // A requester granted last cycle sits out this one.
        eligible = req & ~gntQ & {2{arbActive}};
        if (eligible == 2'b11) begin
            pick = ptrQ ? 2'b10 : 2'b01;
        end else begin
            pick = eligible;
        end

        selG = pick[1] ? sel[3:2] : sel[1:0];
        if (fault) begin
            readWord = (selG == SEL_STATUS) ? {28'h0, status} : '0;
        end else begin
            readWord = fieldDecode(lockedWordQ, selG, status);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gntQ     <= '0;
            ptrQ     <= 1'b0;
            rdDataQ  <= '0;
            rdValidQ <= 1'b0;
            rdErrQ   <= 1'b0;
        end else begin
            gntQ     <= pick;
            rdValidQ <= |pick;
            rdDataQ  <= (|pick) ? readWord : '0;
            rdErrQ   <= (|pick) & fault;
            if (|pick) begin
                ptrQ <= ~pick[1];
            end
        end
    end

    assign gnt      = gntQ;
    assign rd_data  = rdDataQ;
    assign rd_valid = rdValidQ;
    assign rd_err   = rdErrQ;

endmodule
